// File: rtl/fetch_decode.sv
// ==========================================================================
// fetch_decode: byte-serial RV32 instruction fetch with registered field and
// immediate decode, held under a valid/ready handshake.  Revision 1.0
// ==========================================================================
`default_nettype none

module fetch_decode #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              flush,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   output logic [6:0]        opcode,
   output logic [4:0]        rd,
   output logic [2:0]        funct3,
   output logic [4:0]        rs1,
   output logic [4:0]        rs2,
   output logic [6:0]        funct7,
   output logic [31:0]       imm_i_type,
   output logic [31:0]       imm_s_type,
   output logic [31:0]       imm_b_type,
   output logic [31:0]       imm_u_type,
   output logic [31:0]       imm_j_type,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic              misaligned
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [23:0]       buf_q, buf_d;
   logic [31:0]       instr_pc_q, instr_pc_d;
   logic              dec_valid_q, dec_valid_d;
   logic              misaligned_q, misaligned_d;
   logic              load;

   logic [31:0] instr_q, instr_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rs1_q, rs1_d;
   logic [4:0]  rs2_q, rs2_d;
   logic [6:0]  funct7_q, funct7_d;
   logic [31:0] imm_i_q, imm_i_d;
   logic [31:0] imm_s_q, imm_s_d;
   logic [31:0] imm_b_q, imm_b_d;
   logic [31:0] imm_u_q, imm_u_d;
   logic [31:0] imm_j_q, imm_j_d;

   logic        accept;

   assign pc_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_VALID) & dec_ready));
   assign accept    = pc_valid & pc_ready;
   assign imem_addr = ((state_q == S_FETCH) && (cnt_q != 3'd4)) ? base_q + ADDR_W'(cnt_q) : '0;

   // The final byte arrives on imem_rdata in the same cycle the word is decoded.
   assign instr_d  = {imem_rdata, buf_q};
   assign opcode_d = instr_d[6:0];
   assign rd_d     = instr_d[11:7];
   assign funct3_d = instr_d[14:12];
   assign rs1_d    = instr_d[19:15];
   assign rs2_d    = instr_d[24:20];
   assign funct7_d = instr_d[31:25];
   assign imm_i_d  = {{20{instr_d[31]}}, instr_d[31:20]};
   assign imm_s_d  = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
   assign imm_b_d  = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
   assign imm_u_d  = {instr_d[31:12], 12'b0};
   assign imm_j_d  = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      buf_d        = buf_q;
      instr_pc_d   = instr_pc_q;
      dec_valid_d  = dec_valid_q;
      misaligned_d = 1'b0;
      load         = 1'b0;
      if (flush) begin
         state_d     = S_IDLE;
         cnt_d       = 3'd0;
         dec_valid_d = 1'b0;
      end else if (accept) begin
         dec_valid_d = 1'b0;
         if (pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = S_IDLE;
         end else begin
            base_d     = pc[ADDR_W-1:0];
            instr_pc_d = pc;
            cnt_d      = 3'd0;
            state_d    = S_FETCH;
         end
      end else begin
         case (state_q)
            S_FETCH: begin
               cnt_d = cnt_q + 3'd1;
               case (cnt_q)
                  3'd1: buf_d[7:0]   = imem_rdata;
                  3'd2: buf_d[15:8]  = imem_rdata;
                  3'd3: buf_d[23:16] = imem_rdata;
                  3'd4: begin
                     load        = 1'b1;
                     dec_valid_d = 1'b1;
                     cnt_d       = 3'd0;
                     state_d     = S_VALID;
                  end
                  default: ;
               endcase
            end
            S_VALID: begin
               if (dec_ready) begin
                  dec_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         base_q       <= '0;
         buf_q        <= '0;
         instr_pc_q   <= '0;
         dec_valid_q  <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         buf_q        <= buf_d;
         instr_pc_q   <= instr_pc_d;
         dec_valid_q  <= dec_valid_d;
         misaligned_q <= misaligned_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q  <= '0;
         opcode_q <= '0;
         rd_q     <= '0;
         funct3_q <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         funct7_q <= '0;
         imm_i_q  <= '0;
         imm_s_q  <= '0;
         imm_b_q  <= '0;
         imm_u_q  <= '0;
         imm_j_q  <= '0;
      end else if (load) begin
         instr_q  <= instr_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         funct3_q <= funct3_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         funct7_q <= funct7_d;
         imm_i_q  <= imm_i_d;
         imm_s_q  <= imm_s_d;
         imm_b_q  <= imm_b_d;
         imm_u_q  <= imm_u_d;
         imm_j_q  <= imm_j_d;
      end
   end

   assign instr      = instr_q;
   assign instr_pc   = instr_pc_q;
   assign opcode     = opcode_q;
   assign rd         = rd_q;
   assign funct3     = funct3_q;
   assign rs1        = rs1_q;
   assign rs2        = rs2_q;
   assign funct7     = funct7_q;
   assign imm_i_type = imm_i_q;
   assign imm_s_type = imm_s_q;
   assign imm_b_type = imm_b_q;
   assign imm_u_type = imm_u_q;
   assign imm_j_type = imm_j_q;
   assign dec_valid  = dec_valid_q;
   assign misaligned = misaligned_q;

endmodule

`default_nettype wire
